// File: rtl/marquee_ctrl_if.sv
// Button inputs and display/status outputs of the marquee sequencer.
// slave = the sequencer, master = whatever drives the buttons and watches the LEDs.
interface marquee_ctrl_if;
    logic        btn_mode;
    logic        btn_speed;
    logic        btn_pause;
    logic [11:0] Q;
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic        running;
    logic        step_tick;

    modport slave (
        input  btn_mode,
        input  btn_speed,
        input  btn_pause,
        output Q,
        output mode,
        output speed,
        output running,
        output step_tick
    );

    modport master (
        output btn_mode,
        output btn_speed,
        output btn_pause,
        input  Q,
        input  mode,
        input  speed,
        input  running,
        input  step_tick
    );
endinterface

// File: rtl/marquee_ctrl.sv
// 12-LED marquee sequencer: three debounced buttons select pattern, speed and pause;
// a programmable divider paces the pattern steps driving the active-low LED bus.
module marquee_ctrl #(
    parameter int BASE_DIV   = 12_500_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    marquee_ctrl_if.slave bus
);

    localparam int DIV_W = $clog2(BASE_DIV + 1);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] BASE_VAL = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam int BTN_MODE  = 0;
    localparam int BTN_SPEED = 1;
    localparam int BTN_PAUSE = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        MODE_SHL    = 2'd0,
        MODE_SHR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    logic [2:0] w_btn_raw;
    logic [2:0] w_press;

    assign w_btn_raw = {bus.btn_pause, bus.btn_speed, bus.btn_mode};

    // Per button: synchronizer, debounce counter and falling-edge press pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_level;
            logic             r_level_d;
            logic             r_press;
            logic [DEB_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync1   <= 1'b1;
                    r_sync2   <= 1'b1;
                    r_level   <= 1'b1;
                    r_level_d <= 1'b1;
                    r_press   <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    r_press   <= r_level_d & ~r_level;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + DEB_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    mode_e            r_mode,  w_mode_next;
    logic [1:0]       r_speed, w_speed_next;
    logic             r_run,   w_run_next;
    logic [DIV_W-1:0] r_div,   w_div_next;
    logic             r_tick,  w_tick_next;
    logic [11:0]      r_pat,   w_pat_next;
    logic             r_dir,   w_dir_next;
    logic [DIV_W-1:0] w_period;
    logic [DIV_W-1:0] w_period_next;
    logic             w_clear;
    logic             w_step;
    logic             w_dir_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= MODE_SHL;
            r_speed <= 2'd0;
            r_run   <= 1'b1;
            r_div   <= '0;
            r_tick  <= 1'b0;
            r_pat   <= 12'h001;
            r_dir   <= DIR_LEFT;
        end else begin
            r_mode  <= w_mode_next;
            r_speed <= w_speed_next;
            r_run   <= w_run_next;
            r_div   <= w_div_next;
            r_tick  <= w_tick_next;
            r_pat   <= w_pat_next;
            r_dir   <= w_dir_next;
        end
    end

    always_comb begin
        w_clear       = w_press[BTN_MODE] | w_press[BTN_SPEED];
        w_step        = r_tick & ~w_clear;
        w_mode_next   = w_press[BTN_MODE] ? mode_e'(r_mode + 2'd1) : r_mode;
        w_speed_next  = r_speed + {1'b0, w_press[BTN_SPEED]};
        w_run_next    = r_run ^ w_press[BTN_PAUSE];
        w_period      = BASE_VAL >> r_speed;
        w_period_next = BASE_VAL >> w_speed_next;

        // A mode/speed press restarts the period; a paused divider sits at zero.
        if (w_clear || !r_run || !w_run_next) begin
            w_div_next = '0;
        end else if (r_div == w_period - DIV_ONE) begin
            w_div_next = '0;
        end else begin
            w_div_next = r_div + DIV_ONE;
        end
        w_tick_next = w_run_next && (w_div_next == w_period_next - DIV_ONE);

        w_pat_next = r_pat;
        w_dir_next = r_dir;
        w_dir_eff  = r_dir;
        if (w_press[BTN_MODE]) begin
            w_dir_next = DIR_LEFT;
            case (w_mode_next)
                MODE_SHR:  w_pat_next = 12'h800;
                MODE_FILL: w_pat_next = 12'h000;
                default:   w_pat_next = 12'h001;
            endcase
        end else if (w_step) begin
            case (r_mode)
                MODE_SHL: w_pat_next = {r_pat[10:0], r_pat[11]};
                MODE_SHR: w_pat_next = {r_pat[0], r_pat[11:1]};
                MODE_BOUNCE: begin
                    // Turn around at the ends so each endpoint is shown only once.
                    if (r_pat == 12'h800) begin
                        w_dir_eff = DIR_RIGHT;
                    end else if (r_pat == 12'h001) begin
                        w_dir_eff = DIR_LEFT;
                    end
                    w_dir_next = w_dir_eff;
                    w_pat_next = (w_dir_eff == DIR_RIGHT) ? {1'b0, r_pat[11:1]}
                                                          : {r_pat[10:0], 1'b0};
                end
                default: w_pat_next = (r_pat == 12'hFFF) ? 12'h000 : {r_pat[10:0], 1'b1};
            endcase
        end
    end

    assign bus.Q         = ~r_pat;
    assign bus.mode      = r_mode;
    assign bus.speed     = r_speed;
    assign bus.running   = r_run;
    assign bus.step_tick = r_tick & ~w_clear;

endmodule
